// File: rtl/main_clasificador_pkg.sv
// main_clasificador_pkg: shared widths and defaults for the main FIFO, VC FIFOs and routing arbiter
package main_clasificador_pkg;
  localparam int DATA_W         = 6;
  localparam int MAIN_DEPTH     = 4;
  localparam int MAIN_AF_THRESH = 3;
  localparam int MAIN_VC_SEL    = 5;
endpackage

// File: rtl/main_clasificador_fifo.sv
// fifo_main: circular FIFO with occupancy counter, status flags and sticky overflow error
module fifo_main
  import main_clasificador_pkg::*;
#(
  parameter int DEPTH     = MAIN_DEPTH,
  parameter int AF_THRESH = MAIN_AF_THRESH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, wr, rd;
  always_comb begin
    empty       = cnt_q == '0;
    full        = cnt_q == CW'(DEPTH);
    almost_full = cnt_q >= CW'(AF_THRESH);
    error       = err_q;
    head        = mem_q[rd_ptr_q];
    wr          = push & ~full;
    rd          = pop & ~empty;
    wr_ptr_d    = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d       = (wr & ~rd) ? cnt_q + CW'(1) : (rd & ~wr) ? cnt_q - CW'(1) : cnt_q;
    err_d       = err_q | (push & full);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
  // storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) if (wr) mem_q[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/main_clasificador.sv
// main_clasificador: main FIFO steering head words to VC0/VC1 by a data bit under back-pressure
module main_clasificador
  import main_clasificador_pkg::*;
#(
  parameter int DEPTH      = MAIN_DEPTH,
  parameter int AF_THRESH  = MAIN_AF_THRESH,
  parameter int VC_SEL_BIT = MAIN_VC_SEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push_main,
  input  logic              VC0_almost_full,
  input  logic              VC1_almost_full,
  output logic              VC0_push,
  output logic              VC1_push,
  output logic [DATA_W-1:0] VC0_data,
  output logic [DATA_W-1:0] VC1_data,
  output logic              main_empty,
  output logic              main_full,
  output logic              main_almost_full,
  output logic              error_main
);
  logic [DATA_W-1:0] head, vc0_data_q, vc0_data_d, vc1_data_q, vc1_data_d;
  logic vc0_push_q, vc0_push_d, vc1_push_q, vc1_push_d, sel, pop;
  fifo_main #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (data_in),
    .push       (push_main),
    .pop        (pop),
    .head       (head),
    .empty      (main_empty),
    .full       (main_full),
    .almost_full(main_almost_full),
    .error      (error_main)
  );
  // a blocked head stalls everything behind it, keeping strict order
  always_comb begin
    sel        = head[VC_SEL_BIT];
    pop        = ~main_empty & ~(sel ? VC1_almost_full : VC0_almost_full);
    vc0_push_d = pop & ~sel;
    vc1_push_d = pop & sel;
    vc0_data_d = vc0_push_d ? head : vc0_data_q;
    vc1_data_d = vc1_push_d ? head : vc1_data_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc0_push_q <= 1'b0;
      vc1_push_q <= 1'b0;
      vc0_data_q <= '0;
      vc1_data_q <= '0;
    end else begin
      vc0_push_q <= vc0_push_d;
      vc1_push_q <= vc1_push_d;
      vc0_data_q <= vc0_data_d;
      vc1_data_q <= vc1_data_d;
    end
  end
  assign VC0_push = vc0_push_q;
  assign VC1_push = vc1_push_q;
  assign VC0_data = vc0_data_q;
  assign VC1_data = vc1_data_q;
endmodule

// File: doc/main_clasificador.md
MAIN_CLASIFICADOR -- requirements
Module: main_clasificador

Interface
REQ-001 Parameter DEPTH, default 4, main FIFO entries (power of two).
REQ-002 Parameter AF_THRESH, default 3, occupancy at or above which main_almost_full asserts.
REQ-003 Parameter VC_SEL_BIT, default 5, data bit selecting VC1 (1) or VC0 (0).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  6  word from upstream.
REQ-007 push_main  input  1  upstream write strobe, sampled at rising edge.
REQ-008 VC0_almost_full  input  1  back-pressure from VC0 FIFO.
REQ-009 VC1_almost_full  input  1  back-pressure from VC1 FIFO.
REQ-010 VC0_push  output  1  registered write strobe to VC0 FIFO.
REQ-011 VC1_push  output  1  registered write strobe to VC1 FIFO.
REQ-012 VC0_data  output  6  registered word to VC0 FIFO.
REQ-013 VC1_data  output  6  registered word to VC1 FIFO.
REQ-014 main_empty  output  1  occupancy == 0.
REQ-015 main_full  output  1  occupancy == DEPTH.
REQ-016 main_almost_full  output  1  occupancy >= AF_THRESH; pause to upstream.
REQ-017 error_main  output  1  sticky overflow flag.

Function
REQ-018 Main FIFO SHALL be circular: write pointer, read pointer (log2(DEPTH) bits, wrap DEPTH-1 -> 0), occupancy counter (log2(DEPTH)+1 bits).
REQ-019 Write SHALL occur when push_main=1 and main_full=0; data_in stored at write pointer, pointer increments.
REQ-020 push_main=1 while main_full=1 SHALL drop the word, leave state unchanged, set error_main=1 until reset.
REQ-021 Pop condition SHALL be main_empty=0 and almost_full of VC selected by head word bit VC_SEL_BIT equal 0.
REQ-022 On pop: head word registered onto selected VCx_data, selected VCx_push=1 for one cycle, read pointer increments.
REQ-023 When no pop: both VCx_push=0; VCx_data SHALL hold last value.
REQ-024 VC0_push and VC1_push SHALL never be 1 in the same cycle.
REQ-025 Head-of-line order SHALL be preserved: blocked head stalls all pops, no reordering/bypass.
REQ-026 Simultaneous accepted write and pop: occupancy unchanged.
REQ-027 Write into empty FIFO SHALL not pop the same edge; earliest VCx_push is the following edge (latency 2 edges from push_main sample to VCx_push high).
REQ-028 Write when full and pop on same edge: write still dropped (full evaluated before pop), error_main set.
REQ-029 Status flags SHALL be combinational from occupancy counter.

Reset
REQ-030 reset=1 SHALL asynchronously clear pointers, occupancy, error_main, VC0_push, VC1_push, VC0_data=0, VC1_data=0.
REQ-031 After reset: main_empty=1, main_full=0, main_almost_full=0.
REQ-032 Reset mid-operation SHALL discard all stored words; no push emitted on release edge.

Structure
REQ-033 Shared package SHALL hold data width 6, DEPTH, AF_THRESH, VC_SEL_BIT defaults, reused by VC FIFOs and routing arbiter.
REQ-034 Storage, pointers and flags SHALL be sub-module fifo_main; top adds pop logic, VC steering, output registers.

Verification
REQ-035 Reset then push 0x25 (bit5=1), VC almost_full low -> VC1_push=1 with VC1_data=0x25 two edges after sample, VC0_push stays 0.
REQ-036 Push 0x05,0x2A,0x11 back-to-back -> VC0 0x05, VC1 0x2A, VC0 0x11 on consecutive cycles, order kept.
REQ-037 VC0_almost_full=1, push 0x01 then 0x21 -> no pops, occupancy 2; release -> 0x01 to VC0 then 0x21 to VC1.
REQ-038 Both almost_full=1, push 5 words -> main_almost_full=1 at occupancy 3, main_full=1 at 4, 5th dropped, error_main=1 sticky.
REQ-039 Pointer wrap: 10 words streamed with no back-pressure -> all 10 delivered in order, flags correct across wrap.
REQ-040 Assert reset with 3 words stored -> outputs zero immediately, main_empty=1, error_main=0, no push after release.
